// File: rtl/std_seq_mem_d1.sv
// rtl/std_seq_mem_d1.sv - 1-D memory with pipelined registered reads and done pulses
module std_seq_mem_d1 #(
    parameter int WIDTH        = 32,
    parameter int SIZE         = 16,
    parameter int IDX_SIZE     = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [IDX_SIZE-1:0] addr0,
    input  logic [WIDTH-1:0]    write_data,
    input  logic                write_en,
    input  logic                read_en,
    output logic [WIDTH-1:0]    read_data,
    output logic                read_done,
    output logic                write_done,
    output logic                oob_err
);

    if ((2 ** IDX_SIZE) < SIZE || READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_param_err
        $error("std_seq_mem_d1: need 2**IDX_SIZE >= SIZE and READ_LATENCY in 1..4");
    end

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] read_data_q;
    logic             read_done_q;
    logic             write_done_q;
    logic             oob_q;
    logic             oob_d;
    logic             in_range;
    logic [WIDTH-1:0] rd_word;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;

    assign in_range = (32'(addr0) < SIZE);

    // Read-first: the word is sampled before this edge's write lands.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem_q[addr0];
        end
    end

    always_ff @(posedge clk) begin
        if (write_en && in_range) begin
            mem_q[addr0] <= write_data;
        end
    end

    // READ_LATENCY-1 stages sit between the array sample and the output register.
    if (READ_LATENCY == 1) begin : g_direct
        assign out_vld  = read_en;
        assign out_data = rd_word;
    end else begin : g_pipe
        logic [READ_LATENCY-2:0] pvld_q;
        logic [WIDTH-1:0]        pdata_q [READ_LATENCY-1];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pvld_q <= '0;
            end else begin
                pvld_q[0] <= read_en;
                for (int k = 1; k < READ_LATENCY - 1; k++) begin
                    pvld_q[k] <= pvld_q[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            pdata_q[0] <= rd_word;
            for (int k = 1; k < READ_LATENCY - 1; k++) begin
                pdata_q[k] <= pdata_q[k-1];
            end
        end

        assign out_vld  = pvld_q[READ_LATENCY-2];
        assign out_data = pdata_q[READ_LATENCY-2];
    end

    assign oob_d = oob_q | ((read_en | write_en) & ~in_range);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_q  <= '0;
            read_done_q  <= 1'b0;
            write_done_q <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            read_done_q  <= out_vld;
            write_done_q <= write_en;
            oob_q        <= oob_d;
            if (out_vld) begin
                read_data_q <= out_data;
            end
        end
    end

    assign read_data  = read_data_q;
    assign read_done  = read_done_q;
    assign write_done = write_done_q;
    assign oob_err    = oob_q;

endmodule

// File: tb/tb_std_seq_mem_d1.sv
// tb/tb_std_seq_mem_d1.sv - bench for std_seq_mem_d1 over three parameter sets
module tb_std_seq_mem_d1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;

    wire [31:0] rd0, rd1, rd2;
    wire        rdn0, rdn1, rdn2;
    wire        wdn0, wdn1, wdn2;
    wire        oob0, oob1, oob2;

    always #5 clk = ~clk;

    std_seq_mem_d1 #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4), .READ_LATENCY(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .addr0(addr), .write_data(wdata),
        .write_en(we), .read_en(re), .read_data(rd0), .read_done(rdn0),
        .write_done(wdn0), .oob_err(oob0));

    std_seq_mem_d1 #(.WIDTH(32), .SIZE(15), .IDX_SIZE(4), .READ_LATENCY(2)) u_oob (
        .clk(clk), .reset_n(reset_n), .addr0(addr), .write_data(wdata),
        .write_en(we), .read_en(re), .read_data(rd1), .read_done(rdn1),
        .write_done(wdn1), .oob_err(oob1));

    std_seq_mem_d1 #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4), .READ_LATENCY(4)) u_l4 (
        .clk(clk), .reset_n(reset_n), .addr0(addr), .write_data(wdata),
        .write_en(we), .read_en(re), .read_data(rd2), .read_done(rdn2),
        .write_done(wdn2), .oob_err(oob2));

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] g_rd(input int d);
        return (d == 0) ? rd0 : (d == 1) ? rd1 : rd2;
    endfunction
    function automatic logic g_rdone(input int d);
        return (d == 0) ? rdn0 : (d == 1) ? rdn1 : rdn2;
    endfunction
    function automatic logic g_wdone(input int d);
        return (d == 0) ? wdn0 : (d == 1) ? wdn1 : wdn2;
    endfunction
    function automatic logic g_oob(input int d);
        return (d == 0) ? oob0 : (d == 1) ? oob1 : oob2;
    endfunction

    // Reference model: per-DUT word store plus a timeline of reads due per edge.
    int          sz [3] = '{16, 15, 16};
    int          lt [3] = '{2, 2, 4};
    logic [31:0] mm [3][16];
    bit          mk [3][16];
    bit          sv [3][8];
    logic [31:0] sval [3][8];
    bit          sk [3][8];
    logic [31:0] last_rd [3];
    bit          last_k [3];
    bit          m_oob [3];
    bit          m_wd;
    int          edge_n = 0;

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 8; s++) sv[d][s] = 1'b0;
            last_rd[d] = 32'h0;
            last_k[d]  = 1'b1;
            m_oob[d]   = 1'b0;
        end
        m_wd = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_rdata_%0d", tag, d), g_rd(d), 32'h0);
            chk($sformatf("%s_rdone_%0d", tag, d), 32'(g_rdone(d)), 32'h0);
            chk($sformatf("%s_wdone_%0d", tag, d), 32'(g_wdone(d)), 32'h0);
            chk($sformatf("%s_oob_%0d", tag, d), 32'(g_oob(d)), 32'h0);
        end
    endtask

    task automatic step(input bit we_i, input bit re_i, input logic [3:0] a, input logic [31:0] dat);
        int slot;
        bit exp_rd;
        we    = we_i;
        re    = re_i;
        addr  = a;
        wdata = dat;
        edge_n++;
        for (int d = 0; d < 3; d++) begin
            if (re_i) begin
                slot = (edge_n + lt[d] - 1) % 8;
                sv[d][slot] = 1'b1;
                if (int'(a) < sz[d]) begin
                    sval[d][slot] = mm[d][a];
                    sk[d][slot]   = mk[d][a];
                end else begin
                    sval[d][slot] = 32'h0;
                    sk[d][slot]   = 1'b1;
                end
            end
            if (we_i && int'(a) < sz[d]) begin
                mm[d][a] = dat;
                mk[d][a] = 1'b1;
            end
            if ((we_i || re_i) && int'(a) >= sz[d]) m_oob[d] = 1'b1;
        end
        m_wd = we_i;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            slot   = edge_n % 8;
            exp_rd = sv[d][slot];
            if (exp_rd) begin
                last_rd[d]   = sval[d][slot];
                last_k[d]    = sk[d][slot];
                sv[d][slot]  = 1'b0;
            end
            chk($sformatf("m_rdone_%0d_e%0d", d, edge_n), 32'(g_rdone(d)), 32'(exp_rd));
            chk($sformatf("m_wdone_%0d_e%0d", d, edge_n), 32'(g_wdone(d)), 32'(m_wd));
            chk($sformatf("m_oob_%0d_e%0d", d, edge_n), 32'(g_oob(d)), 32'(m_oob[d]));
            if (last_k[d]) chk($sformatf("m_rdata_%0d_e%0d", d, edge_n), g_rd(d), last_rd[d]);
        end
    endtask

    typedef struct {
        bit          we;
        bit          re;
        logic [3:0]  a;
        logic [31:0] d;
        bit          erd;
        bit          ewd;
        logic [31:0] erdata;
    } vec_t;

    vec_t tbl [19];

    task automatic set_v(input int i, input bit w, input bit r, input int a, input logic [31:0] d,
                         input bit erd, input bit ewd, input logic [31:0] er);
        tbl[i] = '{w, r, 4'(a), d, erd, ewd, er};
    endtask

    initial begin
        // write-then-read, pipelined reads, read/write collision on default DUT
        set_v( 0, 1, 0, 5, 32'hDEADBEEF, 0, 1, 32'h0);
        set_v( 1, 0, 1, 5, 32'h0,        0, 0, 32'h0);
        set_v( 2, 0, 0, 0, 32'h0,        1, 0, 32'hDEADBEEF);
        set_v( 3, 0, 0, 0, 32'h0,        0, 0, 32'hDEADBEEF);
        set_v( 4, 1, 0, 0, 32'd10,       0, 1, 32'hDEADBEEF);
        set_v( 5, 1, 0, 1, 32'd20,       0, 1, 32'hDEADBEEF);
        set_v( 6, 1, 0, 2, 32'd30,       0, 1, 32'hDEADBEEF);
        set_v( 7, 1, 0, 3, 32'd40,       0, 1, 32'hDEADBEEF);
        set_v( 8, 0, 1, 0, 32'h0,        0, 0, 32'hDEADBEEF);
        set_v( 9, 0, 1, 1, 32'h0,        1, 0, 32'd10);
        set_v(10, 0, 1, 2, 32'h0,        1, 0, 32'd20);
        set_v(11, 0, 1, 3, 32'h0,        1, 0, 32'd30);
        set_v(12, 0, 0, 0, 32'h0,        1, 0, 32'd40);
        set_v(13, 0, 0, 0, 32'h0,        0, 0, 32'd40);
        set_v(14, 1, 0, 7, 32'd1,        0, 1, 32'd40);
        set_v(15, 1, 1, 7, 32'd2,        0, 1, 32'd40);
        set_v(16, 0, 1, 7, 32'h0,        1, 0, 32'd1);
        set_v(17, 0, 0, 0, 32'h0,        1, 0, 32'd2);
        set_v(18, 0, 0, 0, 32'h0,        0, 0, 32'd2);

        reset_n = 1'b0;
        we = 1'b0; re = 1'b0; addr = 4'h0; wdata = 32'h0;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) mk[d][i] = 1'b0;
        model_reset();
        #12;
        check_zero("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_rdone", i), 32'(rdn0), 32'(tbl[i].erd));
            chk($sformatf("tbl%0d_wdone", i), 32'(wdn0), 32'(tbl[i].ewd));
            chk($sformatf("tbl%0d_rdata", i), rd0, tbl[i].erdata);
        end

        // out-of-range on the SIZE=15 instance; addr 15 is valid on the others
        step(1, 0, 4'd15, 32'h55);
        chk("oob_wdone_on_ignored_write", 32'(wdn1), 32'h1);
        chk("oob_set", 32'(oob1), 32'h1);
        step(1, 0, 4'd15, 32'hAA);
        step(0, 1, 4'd15, 32'h0);
        step(0, 0, 4'd0, 32'h0);
        chk("oob_rdone", 32'(rdn1), 32'h1);
        chk("oob_rdata_zero", rd1, 32'h0);
        chk("inrange_rdata", rd0, 32'hAA);
        chk("inrange_no_oob", 32'(oob0), 32'h0);
        step(1, 0, 4'd2, 32'h33);
        step(0, 1, 4'd2, 32'h0);
        step(0, 0, 4'd0, 32'h0);
        chk("oob_sticky", 32'(oob1), 32'h1);
        chk("oob_inst_inrange_read", rd1, 32'h33);

        // reset mid-read on the latency-4 instance, plus async reset check
        step(0, 1, 4'd5, 32'h0);
        step(0, 0, 4'd0, 32'h0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_zero("midrst");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 32'h0);
        step(0, 1, 4'd5, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 32'h0);
        chk("l4_done_after_reset", 32'(rdn2), 32'h1);
        chk("l4_mem_kept", rd2, 32'hDEADBEEF);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), $urandom);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
